// File: rtl/console_writer_pkg.sv
// Shared definitions for the text console: writer FSM states, control codes and
// the tile-memory address map used by both the writer and the scanout.
package console_writer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_PUT     = 2'd1;
    localparam state_t ST_CLR_ROW = 2'd2;
    localparam state_t ST_CLR_ALL = 2'd3;

    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;

    localparam logic [15:0] INDEX_BASE = 16'h4800;
    localparam logic [15:0] TILES_BASE = 16'h4000;

    // The index map is laid out 32 cells per row, so row*32+col is a plain concatenation.
    function automatic logic [15:0] cell_addr(input logic [15:0] base,
                                              input logic [4:0]  row,
                                              input logic [4:0]  col);
        return base + {6'b0, row, col};
    endfunction

endpackage

// File: rtl/console_writer.sv
// Character-stream console writer: turns characters and control codes into
// tile-index writes, with row and full-screen clears.
module console_writer
    import console_writer_pkg::*;
#(
    parameter logic [15:0] P_index_base = INDEX_BASE,
    parameter int          P_cols       = 32,
    parameter int          P_rows       = 30,
    parameter logic [7:0]  P_fill       = 8'h20
) (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic [7:0]  I_char_data,
    input  logic        I_char_valid,
    output logic        O_char_ready,
    output logic [15:0] O_mem_addr,
    output logic [7:0]  O_mem_data,
    output logic        O_mem_write,
    input  logic        I_mem_wait,
    output logic [4:0]  O_cursor_col,
    output logic [4:0]  O_cursor_row,
    output logic        O_busy
);

    localparam logic [4:0]  COL_LAST = 5'(P_cols - 1);
    localparam logic [4:0]  ROW_LAST = 5'(P_rows - 1);
    localparam logic [10:0] LAST_ALL = 11'(P_cols * P_rows - 1);
    localparam logic [10:0] LAST_ROW = 11'(P_cols - 1);

    state_t      state;
    logic [4:0]  cur_col, cur_row;
    logic [4:0]  clr_col, clr_row;
    logic [10:0] clr_idx;
    logic        put_adv;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;

    logic [4:0]  cur_row_next;
    logic [4:0]  clr_col_next, clr_row_next;
    logic        clr_last;

    always_comb begin
        cur_row_next = (cur_row == ROW_LAST) ? 5'd0 : cur_row + 5'd1;
        clr_col_next = (clr_col == COL_LAST) ? 5'd0 : clr_col + 5'd1;
        clr_row_next = clr_row;
        if (clr_col == COL_LAST)
            clr_row_next = (clr_row == ROW_LAST) ? 5'd0 : clr_row + 5'd1;
        clr_last = (state == ST_CLR_ALL) ? (clr_idx == LAST_ALL) : (clr_idx == LAST_ROW);
    end

    // NOTE: all state uses non-blocking assignments so every branch below reads
    // pre-edge values; the reset branch is asynchronous and restarts the full clear.
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            state     <= ST_CLR_ALL;
            cur_col   <= 5'd0;
            cur_row   <= 5'd0;
            clr_col   <= 5'd0;
            clr_row   <= 5'd0;
            clr_idx   <= 11'd0;
            put_adv   <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= P_index_base;
            mem_data  <= P_fill;
        end else begin
            case (state)
                ST_IDLE: if (I_char_valid) begin
                    case (I_char_data)
                        CC_CR: cur_col <= 5'd0;
                        CC_LF: begin
                            cur_col   <= 5'd0;
                            cur_row   <= cur_row_next;
                            state     <= ST_CLR_ROW;
                            clr_idx   <= 11'd0;
                            clr_col   <= 5'd0;
                            clr_row   <= cur_row_next;
                            mem_addr  <= cell_addr(P_index_base, cur_row_next, 5'd0);
                            mem_data  <= P_fill;
                            mem_write <= 1'b1;
                        end
                        CC_FF: begin
                            cur_col   <= 5'd0;
                            cur_row   <= 5'd0;
                            state     <= ST_CLR_ALL;
                            clr_idx   <= 11'd0;
                            clr_col   <= 5'd0;
                            clr_row   <= 5'd0;
                            mem_addr  <= P_index_base;
                            mem_data  <= P_fill;
                            mem_write <= 1'b1;
                        end
                        CC_BS: if (cur_col != 5'd0) begin
                            cur_col   <= cur_col - 5'd1;
                            state     <= ST_PUT;
                            put_adv   <= 1'b0;
                            mem_addr  <= cell_addr(P_index_base, cur_row, cur_col - 5'd1);
                            mem_data  <= P_fill;
                            mem_write <= 1'b1;
                        end
                        default: begin
                            state     <= ST_PUT;
                            put_adv   <= 1'b1;
                            mem_addr  <= cell_addr(P_index_base, cur_row, cur_col);
                            mem_data  <= I_char_data;
                            mem_write <= 1'b1;
                        end
                    endcase
                end

                // The cursor only advances once the character write has landed.
                ST_PUT: if (!I_mem_wait) begin
                    if (put_adv && cur_col == COL_LAST) begin
                        cur_col   <= 5'd0;
                        cur_row   <= cur_row_next;
                        state     <= ST_CLR_ROW;
                        clr_idx   <= 11'd0;
                        clr_col   <= 5'd0;
                        clr_row   <= cur_row_next;
                        mem_addr  <= cell_addr(P_index_base, cur_row_next, 5'd0);
                        mem_data  <= P_fill;
                    end else begin
                        if (put_adv)
                            cur_col <= cur_col + 5'd1;
                        mem_write <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                // Straight out of reset no write is pending yet; the first cycle raises the strobe.
                ST_CLR_ROW, ST_CLR_ALL: begin
                    if (!mem_write) begin
                        mem_write <= 1'b1;
                    end else if (!I_mem_wait) begin
                        if (clr_last) begin
                            mem_write <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            clr_idx  <= clr_idx + 11'd1;
                            clr_col  <= clr_col_next;
                            clr_row  <= clr_row_next;
                            mem_addr <= cell_addr(P_index_base, clr_row_next, clr_col_next);
                        end
                    end
                end
            endcase
        end
    end

    assign O_char_ready = (state == ST_IDLE);
    assign O_busy       = (state != ST_IDLE);
    assign O_mem_write  = mem_write;
    assign O_mem_addr   = mem_addr;
    assign O_mem_data   = mem_data;
    assign O_cursor_col = cur_col;
    assign O_cursor_row = cur_row;

endmodule

// File: doc/console_writer.md
CONSOLE_WRITER -- requirements
Module: console_writer

Interface
REQ-001 SHALL have parameter P_index_base, default 16'h4800, meaning the byte address of tile-index cell (row 0, column 0).
REQ-002 SHALL have parameter P_cols, default 32, meaning the columns per row (256 px / 8).
REQ-003 SHALL have parameter P_rows, default 30, meaning the rows per screen (240 px / 8).
REQ-004 SHALL have parameter P_fill, default 8'h20, meaning the tile index written when a cell is cleared.
REQ-005 SHALL have port I_clock, input, 1 bit: the system clock; all state changes on its rising edge.
REQ-006 SHALL have port I_reset, input, 1 bit: the reset; reset I_reset, asynchronous, active-low; clock I_clock.
REQ-007 SHALL have port I_char_data, input, 8 bits: the character or control code.
REQ-008 SHALL have port I_char_valid, input, 1 bit: I_char_data is valid.
REQ-009 SHALL have port O_char_ready, output, 1 bit: the block accepts a character this cycle.
REQ-010 SHALL have port O_mem_addr, output, 16 bits: the write address.
REQ-011 SHALL have port O_mem_data, output, 8 bits: the write data.
REQ-012 SHALL have port O_mem_write, output, 1 bit: the write strobe.
REQ-013 SHALL have port I_mem_wait, input, 1 bit: the memory stall.
REQ-014 SHALL have port O_cursor_col, output, 5 bits: the cursor column.
REQ-015 SHALL have port O_cursor_row, output, 5 bits: the cursor row.
REQ-016 SHALL have port O_busy, output, 1 bit: the FSM is not in IDLE.

Function
REQ-017 Cell address SHALL be P_index_base + row*32 + col, computed in 16 bits; this matches the scanout's index fetch layout.
REQ-018 FSM states SHALL be IDLE, PUT, CLR_ROW, CLR_ALL.
REQ-019 O_char_ready SHALL be 1 only in IDLE; a transfer occurs when I_char_valid && O_char_ready; I_char_data SHALL be ignored otherwise.
REQ-020 Printable character (any code other than 08/0A/0C/0D): IDLE->PUT. The write of that code at the cursor SHALL appear on O_mem_write in the cycle after acceptance. The cursor then advances.
REQ-021 Cursor advance: col<P_cols-1 -> col+1, back to IDLE. col==P_cols-1 -> col=0, row+1 (P_rows-1 wraps to 0), then CLR_ROW.
REQ-022 0x0D (CR): col=0, no memory write, remain IDLE (ready again next cycle).
REQ-023 0x0A (LF): col=0, row advances with the wrap rule, then CLR_ROW.
REQ-024 0x08 (BS): if col>0, col-1 and write P_fill at the new position via PUT without advance. If col==0, no action.
REQ-025 0x0C (FF): cursor to (0,0), then CLR_ALL.
REQ-026 CLR_ROW SHALL write P_fill to columns 0..P_cols-1 of the cursor row, one write per non-stalled cycle, in ascending address order, then go to IDLE; the cursor is unchanged.
REQ-027 CLR_ALL SHALL write P_fill to all P_cols*P_rows cells (960 by default) in ascending address order, then go to IDLE.
REQ-028 Clear counters SHALL be an 11-bit linear index; termination SHALL compare against P_cols*P_rows-1 exactly, with no off-by-one extra write.
REQ-029 When I_mem_wait=1 while O_mem_write=1, addr/data/write SHALL hold stable and no progress SHALL occur; the write completes in the first cycle with I_mem_wait=0.
REQ-030 O_mem_write SHALL be 0 in IDLE; O_mem_addr/O_mem_data SHALL hold their last values when O_mem_write=0.
REQ-031 O_cursor_col/O_cursor_row SHALL update in the cycle the cursor move is decided; during a clear they show the post-move cursor.

Reset
REQ-032 While I_reset=0: state=CLR_ALL, clear index=0, cursor=(0,0), O_char_ready=0, O_mem_write=0, O_mem_addr=P_index_base, O_mem_data=P_fill, O_busy=1.
REQ-033 After reset release, the block SHALL perform a full CLR_ALL before first accepting a character.
REQ-034 Reset asserted mid-operation SHALL abort any write or clear; after release the sequence SHALL restart per REQ-033.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, control-code constants (08/0A/0C/0D), and the P_index_base/P_tiles_base (16'h4000) address constants used by both scanout and writer.
REQ-036 The design SHALL be a single module with no sub-module; the address generator (row*32+col) SHALL be a shift/concatenation, not a multiplier.

Verification
REQ-037 Reset release with I_mem_wait=0 -> exactly 960 writes of 8'h20 at 16'h4800..16'h4BBF, then O_char_ready=1.
REQ-038 Send 'A' (8'h41) at cursor (0,0) -> one write addr 16'h4800 data 8'h41 the next cycle; cursor becomes (1,0).
REQ-039 Cursor (31,2), send 8'h42 -> write 16'h485F=8'h42, cursor (0,3), then 32 writes 8'h20 at 16'h4860..16'h487F.
REQ-040 Cursor (5,29), send 8'h0A -> cursor (0,0), 32 writes 8'h20 at 16'h4800..16'h481F.
REQ-041 During CLR_ALL, hold I_mem_wait=1 for 3 cycles at address 16'h4810 -> addr/data stable 4 cycles, no skipped or duplicated address.
REQ-042 Cursor (0,4), send 8'h08 -> no write, cursor unchanged; cursor (3,4), send 8'h08 -> write 16'h4882=8'h20, cursor (2,4).
